// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) with HI/LO result registers.
// Optional macro MULTDIV_UNSIGNED_EN enables the multu/divu variant via op_unsigned.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             op_unsigned,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               sign_q, sign_d;
   logic               rsign_q, rsign_d;
   logic               is_div_q, is_div_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               uns;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] mnext;
   logic [WIDTH:0]     dshift;
   logic [WIDTH-1:0]   ddiff;
   logic               dge;
   logic [2*WIDTH-1:0] dnext;
   logic [2*WIDTH-1:0] prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

`ifdef MULTDIV_UNSIGNED_EN
   assign uns = op_unsigned;
`else
   assign uns = op_unsigned & 1'b0;
`endif

   assign a_neg = a_in[WIDTH-1] & ~uns;
   assign b_neg = b_in[WIDTH-1] & ~uns;
   assign a_mag = a_neg ? -a_in : a_in;
   assign b_mag = b_neg ? -b_in : b_in;

   // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
   assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mnext = {(acc_q[0] ? msum : {1'b0, acc_q[2*WIDTH-1:WIDTH]}), acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend/quotient bits}; remainder never exceeds the divisor.
   assign dshift = acc_q[2*WIDTH-1:WIDTH-1];
   assign dge    = dshift >= {1'b0, opb_q};
   assign ddiff  = dshift[WIDTH-1:0] - opb_q;
   assign dnext  = {(dge ? ddiff : dshift[WIDTH-1:0]), acc_q[WIDTH-2:0], dge};

   assign prod_fin = sign_q  ? -acc_q : acc_q;
   assign quo_fin  = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fin  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      sign_d     = sign_q;
      rsign_d    = rsign_q;
      is_div_d   = is_div_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         IDLE: begin
            if (start_mult) begin
               state_d  = MULT;
               cnt_d    = CNT_W'(WIDTH);
               acc_d    = {{WIDTH{1'b0}}, b_mag};
               opb_d    = a_mag;
               sign_d   = a_neg ^ b_neg;
               is_div_d = 1'b0;
               busy_d   = 1'b1;
            end else if (start_div) begin
               if (b_in == '0) begin
                  div_zero_d = 1'b1;
               end else begin
                  state_d  = DIV;
                  cnt_d    = CNT_W'(WIDTH);
                  acc_d    = {{WIDTH{1'b0}}, a_mag};
                  opb_d    = b_mag;
                  sign_d   = a_neg ^ b_neg;
                  rsign_d  = a_neg;
                  is_div_d = 1'b1;
                  busy_d   = 1'b1;
               end
            end
         end
         MULT, DIV: begin
            acc_d = (state_q == DIV) ? dnext : mnext;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = FIN;
         end
         FIN: begin
            if (is_div_q) begin
               hi_d = rem_fin;
               lo_d = quo_fin;
            end else begin
               hi_d = prod_fin[2*WIDTH-1:WIDTH];
               lo_d = prod_fin[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         sign_q     <= 1'b0;
         rsign_q    <= 1'b0;
         is_div_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         sign_q     <= sign_d;
         rsign_q    <= rsign_d;
         is_div_q   <= is_div_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operands against an arithmetic reference.
module tb_mult_div_unit;

`ifdef MULTDIV_UNSIGNED_EN
   localparam bit UNS_EN = 1'b1;
`else
   localparam bit UNS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic        op_unsigned = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi_out, lo_out;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_hl = '0;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .op_unsigned(op_unsigned), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
      .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input bit is_div, input bit uns,
                                         input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     res;
      if (uns) begin
         ua = {32'b0, a};
         ub = {32'b0, b};
         if (is_div) res = {32'(ua % ub), 32'(ua / ub)};
         else        res = ua * ub;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (is_div) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
         end else begin
            res = sa * sb;
         end
      end
      return res;
   endfunction

   task automatic issue(input bit sm, input bit sd, input bit uns,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_mult = sm; start_div = sd; op_unsigned = uns; a_in = a; b_in = b;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0;
      op_unsigned = 1'($urandom); a_in = $urandom; b_in = $urandom;
   endtask

   // Called one half-cycle after the start edge; waits for done and checks the result.
   task automatic expect_done(input string tag, input logic [63:0] exp, input bit poke);
      int n;
      bit seen_done, busy_ok, dz_seen;
      n = 0; seen_done = 0; dz_seen = 0;
      busy_ok = (busy === 1'b1);
      while (!seen_done && n < 40) begin
         if (poke && n == 5) begin
            start_div = 1'b1; a_in = 32'd100; b_in = 32'd0;
         end else begin
            start_div = 1'b0;
         end
         @(negedge clk);
         n++;
         if (div_zero === 1'b1) dz_seen = 1;
         if (done === 1'b1) seen_done = 1;
         else if (busy !== 1'b1) busy_ok = 0;
      end
      start_div = 1'b0;
      chk({tag, " latency"}, 64'(n), 64'd33);
      chk({tag, " busy_during"}, {63'b0, busy_ok}, 64'd1);
      chk({tag, " no_div_zero"}, {63'b0, dz_seen}, 64'd0);
      chk({tag, " hilo"}, {hi_out, lo_out}, exp);
      chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
      exp_hl = exp;
      @(negedge clk);
      chk({tag, " done_pulse"}, {63'b0, done}, 64'd0);
   endtask

   task automatic expect_div_zero(input string tag);
      bit seen_done;
      chk({tag, " div_zero"}, {63'b0, div_zero}, 64'd1);
      chk({tag, " busy"}, {63'b0, busy}, 64'd0);
      seen_done = (done === 1'b1);
      @(negedge clk);
      chk({tag, " div_zero_pulse"}, {63'b0, div_zero}, 64'd0);
      repeat (3) begin
         if (done === 1'b1) seen_done = 1;
         @(negedge clk);
      end
      chk({tag, " no_done"}, {63'b0, seen_done}, 64'd0);
      chk({tag, " hilo_kept"}, {hi_out, lo_out}, exp_hl);
   endtask

   task automatic run_op(input string tag, input bit is_div, input bit uns,
                         input logic [31:0] a, input logic [31:0] b);
      issue(!is_div, is_div, uns, a, b);
      if (is_div && b == 32'd0) expect_div_zero(tag);
      else expect_done(tag, model(is_div, uns && UNS_EN, a, b), 1'b0);
   endtask

   initial begin
      bit          seen_done;
      bit          kind, uns;
      logic [31:0] ra, rb;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset busy", {63'b0, busy}, 64'd0);
      chk("reset done", {63'b0, done}, 64'd0);
      chk("reset div_zero", {63'b0, div_zero}, 64'd0);
      chk("reset hilo", {hi_out, lo_out}, 64'd0);

      // Reset in the middle of a multiply discards it.
      issue(1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset busy", {63'b0, busy}, 64'd0);
      chk("midreset hilo", {hi_out, lo_out}, 64'd0);
      seen_done = 0;
      repeat (40) begin
         if (done === 1'b1) seen_done = 1;
         @(negedge clk);
      end
      chk("midreset no_done", {63'b0, seen_done}, 64'd0);
      exp_hl = '0;

      run_op("mul 5x7", 1'b0, 1'b0, 32'd5, 32'd7);
      chk("mul 5x7 const", {hi_out, lo_out}, 64'd35);
      run_op("mul -3x4", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd4);
      chk("mul -3x4 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF4);
      run_op("div -7/2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
      chk("div -7/2 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div by zero", 1'b1, 1'b0, 32'd100, 32'd0);
      run_op("div min/-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div min/-1 const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

      // Both starts together: multiply wins.
      issue(1'b1, 1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9);
      expect_done("collide", 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

      // A divide-by-zero request while busy must be ignored entirely.
      issue(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      expect_done("busy poke", model(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);

`ifdef MULTDIV_UNSIGNED_EN
      run_op("multu", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
      chk("multu const", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
      run_op("divu", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10);
      chk("divu const", {hi_out, lo_out}, 64'h0000_000F_0FFF_FFFF);
`else
      run_op("uns ignored", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
      chk("uns ignored const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

      for (int i = 0; i < 24; i++) begin
         kind = 1'($urandom);
         uns  = 1'($urandom);
         ra   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 9);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), kind, uns, ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
